// File: rtl/mdio_master.sv
// MDIO (clause 22) management master: serialises read/write frames on MDC/MDIO.
// Optional feature macro MDIO_PREAMBLE_SUPPRESS_EN adds input no_pre to skip the preamble per frame.
module mdio_master #(
   parameter int unsigned CLK_DIV      = 10,
   parameter int unsigned PREAMBLE_LEN = 32
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        start,
   input  logic        op,
   input  logic [4:0]  phy_addr,
   input  logic [4:0]  reg_addr,
   input  logic [15:0] wr_data,
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
   input  logic        no_pre,
`endif
   output logic [15:0] rd_data,
   output logic        ready,
   output logic        done,
   output logic        ta_err,
   output logic        MDC,
   output logic        MDIO_O,
   output logic        MDIO_OE,
   input  logic        MDIO_I
);

   localparam int unsigned DIV_W = 8;
   localparam int unsigned CNT_W = 5;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_LEN - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_PRE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA, S_FIN
   } state_t;

   state_t             state_q, state_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               mdc_q, mdc_d;
   logic               mdio_o_q, mdio_o_d;
   logic               oe_q, oe_d;
   logic               done_q, done_d;
   logic               ready_q, ready_d;
   logic               ta_err_q, ta_err_d;
   logic [15:0]        rd_q, rd_d;
   logic [15:0]        shift_q, shift_d;
   logic               op_q;
   logic [4:0]         phy_q, reg_q;
   logic [15:0]        wr_q;

   logic accept_c, busy_c, half_end_c, bit_end_c, field_last_c, skip_pre_c;

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
   assign skip_pre_c = (PREAMBLE_LEN == 0) || no_pre;
`else
   assign skip_pre_c = (PREAMBLE_LEN == 0);
`endif

   assign accept_c   = start && ready_q;
   assign busy_c     = (state_q != S_IDLE) && (state_q != S_FIN);
   assign half_end_c = busy_c && !mdc_q && (div_q == DIV_LAST);
   assign bit_end_c  = busy_c &&  mdc_q && (div_q == DIV_LAST);

   // Last bit of the current field
   always_comb begin
      field_last_c = 1'b0;
      case (state_q)
         S_PRE:            field_last_c = (cnt_q == PRE_LAST);
         S_ST, S_OP, S_TA: field_last_c = (cnt_q == CNT_W'(1));
         S_PHYAD, S_REGAD: field_last_c = (cnt_q == CNT_W'(4));
         S_DATA:           field_last_c = (cnt_q == CNT_W'(15));
         default:          field_last_c = 1'b0;
      endcase
   end

   // {oe, o} for the bit that starts in field s at index c
   function automatic logic [1:0] frame_bit(state_t s, logic [CNT_W-1:0] c);
      logic [1:0] r;
      r = 2'b01;
      case (s)
         S_PRE:   r = 2'b11;
         S_ST:    r = {1'b1, c != '0};
         S_OP:    r = {1'b1, op_q ? (c == '0) : (c != '0)};
         S_PHYAD: r = {1'b1, phy_q[3'(CNT_W'(4) - c)]};
         S_REGAD: r = {1'b1, reg_q[3'(CNT_W'(4) - c)]};
         S_TA:    r = {!op_q, op_q ? 1'b1 : (c == '0)};
         S_DATA:  r = {!op_q, op_q ? 1'b1 : wr_q[4'(CNT_W'(15) - c)]};
         default: r = 2'b01;
      endcase
      return r;
   endfunction

   // State register
   always_ff @(posedge CLK) begin
      if (!RST_N) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (accept_c) state_d = skip_pre_c ? S_ST : S_PRE;
         S_FIN:  state_d = S_IDLE;
         default: begin
            if (bit_end_c && field_last_c) begin
               case (state_q)
                  S_PRE:   state_d = S_ST;
                  S_ST:    state_d = S_OP;
                  S_OP:    state_d = S_PHYAD;
                  S_PHYAD: state_d = S_REGAD;
                  S_REGAD: state_d = S_TA;
                  S_TA:    state_d = S_DATA;
                  default: state_d = S_FIN;
               endcase
            end
         end
      endcase
   end

   // Output / datapath next values; pins only reload at a bit boundary
   always_comb begin
      logic       load_bit;
      logic [1:0] nb;
      div_d    = '0;
      mdc_d    = 1'b0;
      cnt_d    = cnt_q;
      mdio_o_d = mdio_o_q;
      oe_d     = oe_q;
      done_d   = (state_q == S_FIN);
      ready_d  = (state_d == S_IDLE) && (state_q != S_FIN);
      ta_err_d = ta_err_q;
      shift_d  = shift_q;
      rd_d     = rd_q;
      load_bit = 1'b0;
      if (accept_c) begin
         cnt_d    = '0;
         load_bit = 1'b1;
         if (op) ta_err_d = 1'b0;
      end else if (busy_c) begin
         div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
         mdc_d = (div_q == DIV_LAST) ? !mdc_q : mdc_q;
         if (bit_end_c) begin
            cnt_d    = field_last_c ? '0 : cnt_q + CNT_W'(1);
            load_bit = 1'b1;
         end
         if (half_end_c && op_q) begin
            if (state_q == S_TA && cnt_q == CNT_W'(1)) ta_err_d = MDIO_I;
            if (state_q == S_DATA) shift_d = {shift_q[14:0], MDIO_I};
         end
      end else if (state_q == S_FIN && op_q) begin
         rd_d = shift_q;
      end
      nb = frame_bit(state_d, cnt_d);
      if (load_bit) begin
         oe_d     = nb[1];
         mdio_o_d = nb[0];
      end
   end

   // Output and datapath registers
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         div_q    <= '0;
         cnt_q    <= '0;
         mdc_q    <= 1'b0;
         mdio_o_q <= 1'b1;
         oe_q     <= 1'b0;
         done_q   <= 1'b0;
         ready_q  <= 1'b1;
         ta_err_q <= 1'b0;
         rd_q     <= '0;
         shift_q  <= '0;
         op_q     <= 1'b0;
         phy_q    <= '0;
         reg_q    <= '0;
         wr_q     <= '0;
      end else begin
         div_q    <= div_d;
         cnt_q    <= cnt_d;
         mdc_q    <= mdc_d;
         mdio_o_q <= mdio_o_d;
         oe_q     <= oe_d;
         done_q   <= done_d;
         ready_q  <= ready_d;
         ta_err_q <= ta_err_d;
         rd_q     <= rd_d;
         shift_q  <= shift_d;
         if (accept_c) begin
            op_q  <= op;
            phy_q <= phy_addr;
            reg_q <= reg_addr;
            wr_q  <= wr_data;
         end
      end
   end

   assign rd_data = rd_q;
   assign ready   = ready_q;
   assign done    = done_q;
   assign ta_err  = ta_err_q;
   assign MDC     = mdc_q;
   assign MDIO_O  = mdio_o_q;
   assign MDIO_OE = oe_q;

endmodule
